cnn_window_ctrl: RTL and testbench
==================================

CNN_WINDOW_CTRL -- requirements
Module: cnn_window_ctrl

Interface
REQ-001 IMG_W, 28, image width in pixels (one bit per pixel).
REQ-002 IMG_H, 28, image height in pixels.
REQ-003 AW, 10, RAM address width; IMG_W*IMG_H SHALL be at most 2**AW.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 clr  in  1  synchronous frame restart, one-cycle pulse.
REQ-007 wr_ptr  in  AW  count of pixels already written to input RAM.
REQ-008 core_bsy  in  1  core still processing the previous window.
REQ-009 rd_en  out  1  read strobe to input RAM.
REQ-010 addr_rd  out  AW  read address to input RAM.
REQ-011 tap_vld  out  1  RAM data valid for the core; rd_en delayed by 1 cycle.
REQ-012 tap_idx  out  4  kernel tap index 0..8 aligned with tap_vld.
REQ-013 win_strt  out  1  one-cycle pulse aligned with tap 0.
REQ-014 win_last  out  1  one-cycle pulse aligned with tap 8.
REQ-015 win_row  out  5  top row of the current window.
REQ-016 win_col  out  5  left column of the current window.
REQ-017 frame_done  out  1  level; all windows of the frame have been issued.

Function
REQ-018 The 3x3 kernel size, stride 1, and no padding SHALL be fixed; the frame SHALL contain (IMG_H-2)*(IMG_W-2) windows in raster order.
REQ-019 The FSM SHALL have states IDLE, WAIT, FETCH, ADV and DONE.
REQ-020 IDLE SHALL go to WAIT on the first cycle out of reset or after clr.
REQ-021 The window base SHALL be base = win_row*IMG_W + win_col.
REQ-022 Window ready SHALL mean (base + 2*IMG_W + 2) < wr_ptr.
REQ-023 WAIT SHALL go to FETCH when window ready && !core_bsy; otherwise it SHALL stay in WAIT.
REQ-024 FETCH SHALL last exactly 9 cycles with rd_en=1 and tap t=0..8.
REQ-025 In FETCH, addr_rd SHALL equal base + (t/3)*IMG_W + (t%3).
REQ-026 FETCH SHALL NOT be interrupted by core_bsy or wr_ptr changes.
REQ-027 ADV SHALL be one cycle.
REQ-028 In ADV, if win_col == IMG_W-3 then win_col SHALL become 0 and win_row SHALL increment; otherwise win_col SHALL increment.
REQ-029 After ADV the FSM SHALL go to DONE if the finished window was (IMG_H-3, IMG_W-3); otherwise it SHALL go to WAIT.
REQ-030 DONE SHALL hold frame_done=1 and rd_en=0 until clr.
REQ-031 tap_vld, tap_idx, win_strt and win_last SHALL be registered one cycle after the matching rd_en/addr_rd cycle.
REQ-032 Outside FETCH, rd_en SHALL be 0 and addr_rd SHALL be 0.
REQ-033 clr SHALL take priority over all FSM transitions in every state, including mid-FETCH.
REQ-034 On clr, next cycle: state IDLE, win_row=win_col=0, rd_en=0, frame_done=0.
REQ-035 The delayed tap_vld pipeline register SHALL also clear on clr, so no partial window reaches the core.
REQ-036 The minimum window period SHALL be 11 cycles (WAIT + 9 FETCH + ADV) when data is ready and the core is idle.
REQ-037 Address arithmetic SHALL be AW bits unsigned; the base computation SHALL not overflow within parameter limits.

Reset
REQ-038 While rst_n=0 the block SHALL hold state IDLE, all counters 0, and all outputs 0 (rd_en, addr_rd, tap_vld, tap_idx, win_strt, win_last, win_row, win_col, frame_done).
REQ-039 rst_n assertion mid-FETCH SHALL abort the window immediately.
REQ-040 After reset release the block SHALL restart from window (0,0).

Verification
REQ-041 wr_ptr=58, core_bsy=0 -> no rd_en (58 not > 58); raise wr_ptr to 59 -> FETCH addresses 0,1,2,28,29,30,56,57,58; tap_vld one cycle later with tap_idx 0..8; win_strt on tap 0, win_last on tap 8.
REQ-042 wr_ptr=784, core_bsy=1 held 20 cycles after reset -> rd_en stays 0; deassert core_bsy -> FETCH starts the next cycle.
REQ-043 Column wrap: window (0,25) taps begin at 25 and end at 83; the next window is (1,0) with first address 28.
REQ-044 Full frame with wr_ptr=784, core_bsy=0 -> exactly 676 win_strt pulses; last window base 725 with final address 783; frame_done=1 and held; no further rd_en.
REQ-045 clr asserted at FETCH tap 4 -> next cycle rd_en=0, addr_rd=0, win_row=win_col=0; tap_vld drops after the last already-issued tap; no win_last for the aborted window.
REQ-046 rst_n pulsed low mid-frame -> all outputs 0 asynchronously; after release, fetch resumes at base 0 once window ready.

Source files
------------

// File: rtl/cnn_window_ctrl_if.sv
// Bundle between the 3x3 window controller, the input pixel RAM and the
// convolution core. The controller owns the master side.
interface cnn_window_ctrl_if #(
    parameter int AW = 10
);
    logic          clr;
    logic [AW-1:0] wr_ptr;
    logic          core_bsy;
    logic          rd_en;
    logic [AW-1:0] addr_rd;
    logic          tap_vld;
    logic [3:0]    tap_idx;
    logic          win_strt;
    logic          win_last;
    logic [4:0]    win_row;
    logic [4:0]    win_col;
    logic          frame_done;

    modport master (
        input  clr, wr_ptr, core_bsy,
        output rd_en, addr_rd, tap_vld, tap_idx, win_strt, win_last,
               win_row, win_col, frame_done
    );

    modport slave (
        output clr, wr_ptr, core_bsy,
        input  rd_en, addr_rd, tap_vld, tap_idx, win_strt, win_last,
               win_row, win_col, frame_done
    );
endinterface

// File: rtl/cnn_window_ctrl.sv
// Walks a 3x3, stride-1, unpadded window across a 1-bit image held in the
// input RAM. Each window is fetched as nine back-to-back reads once enough
// pixels have been written and the core is free; RAM data is tagged one
// cycle later with the tap index and start/last markers for the core.
module cnn_window_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int AW    = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cnn_window_ctrl_if.master      bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FETCH,
        ADV,
        DONE
    } state_t;

    localparam logic [AW-1:0] IMG_W_A  = AW'(IMG_W);
    localparam logic [AW-1:0] SPAN     = AW'(2 * IMG_W + 2);
    localparam logic [4:0]    COL_LAST = 5'(IMG_W - 3);
    localparam logic [4:0]    ROW_LAST = 5'(IMG_H - 3);

    state_t        state_q, state_d;
    logic [3:0]    tap_q, tap_d;
    logic [4:0]    winRow_q, winRow_d;
    logic [4:0]    winCol_q, winCol_d;

    logic          tapVld_q;
    logic [3:0]    tapIdx_q;
    logic          winStrt_q;
    logic          winLast_q;

    logic [AW-1:0] base;
    logic          winReady;
    logic          isLastWin;
    logic          rdEn;
    logic [AW-1:0] addrRd;

    // Offset of tap t inside the window: (t/3) rows down, (t%3) columns right.
    function automatic logic [AW-1:0] tapOffset(input logic [3:0] t);
        logic [AW-1:0] r;
        r = '0;
        case (t)
            4'd0:    r = AW'(0);
            4'd1:    r = AW'(1);
            4'd2:    r = AW'(2);
            4'd3:    r = AW'(IMG_W);
            4'd4:    r = AW'(IMG_W + 1);
            4'd5:    r = AW'(IMG_W + 2);
            4'd6:    r = AW'(2 * IMG_W);
            4'd7:    r = AW'(2 * IMG_W + 1);
            4'd8:    r = AW'(2 * IMG_W + 2);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign base      = AW'(winRow_q) * IMG_W_A + AW'(winCol_q);
    assign winReady  = (base + SPAN) < bus.wr_ptr;
    assign isLastWin = (winRow_q == ROW_LAST) && (winCol_q == COL_LAST);

    // State, tap counter and window position registers; reset aborts any fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            winRow_q <= '0;
            winCol_q <= '0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            winRow_q <= winRow_d;
            winCol_q <= winCol_d;
        end
    end

    // Next-state and read-port decode; clr overrides every transition.
    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        winRow_d = winRow_q;
        winCol_d = winCol_q;
        rdEn     = 1'b0;
        addrRd   = '0;

        if (state_q == FETCH) begin
            rdEn   = 1'b1;
            addrRd = base + tapOffset(tap_q);
        end

        if (bus.clr) begin
            state_d  = IDLE;
            tap_d    = '0;
            winRow_d = '0;
            winCol_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    tap_d   = '0;
                end
                WAIT: begin
                    if (winReady && !bus.core_bsy) begin
                        state_d = FETCH;
                        tap_d   = '0;
                    end
                end
                FETCH: begin
                    if (tap_q == 4'd8) begin
                        state_d = ADV;
                        tap_d   = '0;
                    end else begin
                        tap_d = tap_q + 4'd1;
                    end
                end
                ADV: begin
                    if (winCol_q == COL_LAST) begin
                        winCol_d = '0;
                        winRow_d = winRow_q + 5'd1;
                    end else begin
                        winCol_d = winCol_q + 5'd1;
                    end
                    state_d = isLastWin ? DONE : WAIT;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Tap tags follow the RAM read latency by one cycle; clr drops a partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tapVld_q  <= 1'b0;
            tapIdx_q  <= '0;
            winStrt_q <= 1'b0;
            winLast_q <= 1'b0;
        end else if (bus.clr) begin
            tapVld_q  <= 1'b0;
            tapIdx_q  <= '0;
            winStrt_q <= 1'b0;
            winLast_q <= 1'b0;
        end else begin
            tapVld_q  <= rdEn;
            tapIdx_q  <= rdEn ? tap_q : 4'd0;
            winStrt_q <= rdEn && (tap_q == 4'd0);
            winLast_q <= rdEn && (tap_q == 4'd8);
        end
    end

    assign bus.rd_en      = rdEn;
    assign bus.addr_rd    = addrRd;
    assign bus.tap_vld    = tapVld_q;
    assign bus.tap_idx    = tapIdx_q;
    assign bus.win_strt   = winStrt_q;
    assign bus.win_last   = winLast_q;
    assign bus.win_row    = winRow_q;
    assign bus.win_col    = winCol_q;
    assign bus.frame_done = (state_q == DONE);

endmodule

// File: tb/tb_cnn_window_ctrl.sv
// Bench for the 3x3 window controller: a monitor models the expected window
// walk, checks every read address and queues the expected tap tags, which are
// popped and compared when tap_vld appears.
module tb_cnn_window_ctrl;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int AW    = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cnn_window_ctrl_if #(.AW(AW)) bus ();

    cnn_window_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int tapQ[$];
    int mRow = 0, mCol = 0, mTap = 0;
    int cycle = 0;
    int rdCount = 0, strtCount = 0, lastCount = 0;
    int lastStrtCycle = -1, minPeriod = 1000000;
    int lastBase = -1, lastAddr = -1;
    int wrapEnd = -1, wrapNext = -1, firstAddr = -1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic clr, input int wrPtr, input logic coreBsy);
        bus.clr      = clr;
        bus.wr_ptr   = AW'(wrPtr);
        bus.core_bsy = coreBsy;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitRdEn(input string tag, input int budget, output int n);
        n = 0;
        while (bus.rd_en !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.rd_en !== 1'b1) checkOutput(tag, bus.rd_en, 1);
    endtask

    // Monitor: model of the raster walk plus the tap scoreboard.
    always @(negedge clk) begin
        int t;
        int expAddr;
        cycle++;
        if (!rst_n) begin
            checkOutput("resetOutputs",
                        {bus.rd_en, bus.addr_rd, bus.tap_vld, bus.tap_idx, bus.win_strt,
                         bus.win_last, bus.win_row, bus.win_col, bus.frame_done}, 0);
            tapQ.delete();
            mRow = 0;
            mCol = 0;
            mTap = 0;
        end else begin
            if (bus.tap_vld) begin
                if (tapQ.size() == 0) begin
                    checkOutput("spuriousTapVld", 1, 0);
                end else begin
                    t = tapQ.pop_front();
                    checkOutput("tapIdx", bus.tap_idx, t);
                    checkOutput("winStrt", bus.win_strt, (t == 0) ? 1 : 0);
                    checkOutput("winLast", bus.win_last, (t == 8) ? 1 : 0);
                end
            end else begin
                checkOutput("tapVldMissing", tapQ.size(), 0);
                checkOutput("strayPulse", {bus.win_strt, bus.win_last}, 0);
            end
            if (bus.win_strt) begin
                strtCount++;
                if (lastStrtCycle >= 0 && (cycle - lastStrtCycle) < minPeriod)
                    minPeriod = cycle - lastStrtCycle;
                lastStrtCycle = cycle;
            end
            if (bus.win_last) lastCount++;
            if (bus.rd_en) begin
                rdCount++;
                expAddr = (mRow * IMG_W + mCol) + (mTap / 3) * IMG_W + (mTap % 3);
                checkOutput("addrRd", bus.addr_rd, expAddr);
                checkOutput("winPos", {bus.win_row, bus.win_col}, (mRow << 5) | mCol);
                if (firstAddr < 0) firstAddr = int'(bus.addr_rd);
                if (mTap == 0) begin
                    lastBase = int'(bus.addr_rd);
                    if (mRow == 1 && mCol == 0) wrapNext = int'(bus.addr_rd);
                end
                if (mTap == 8) begin
                    lastAddr = int'(bus.addr_rd);
                    if (mRow == 0 && mCol == IMG_W - 3) wrapEnd = int'(bus.addr_rd);
                end
                if (!bus.clr) begin
                    tapQ.push_back(mTap);
                    mTap++;
                    if (mTap == 9) begin
                        mTap = 0;
                        if (mCol == IMG_W - 3) begin
                            mCol = 0;
                            mRow++;
                        end else begin
                            mCol++;
                        end
                    end
                end
            end else begin
                checkOutput("addrIdle", bus.addr_rd, 0);
            end
            if (bus.clr) begin
                mRow = 0;
                mCol = 0;
                mTap = 0;
            end
        end
    end

    initial begin
        int n;
        int snap;
        int rdSnap;

        // Window (0,0) needs pixel 58 written, so wr_ptr=58 must not start it.
        applyStimulus(1'b0, 58, 1'b0);
        rst_n = 1'b0;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(20);
        checkOutput("noFetchAt58", rdCount, 0);
        applyStimulus(1'b0, 59, 1'b0);
        firstAddr = -1;
        waitRdEn("timeoutFetch59", 10, n);
        checkOutput("fetchLatency59", n, 1);
        waitCycles(14);
        checkOutput("firstWindowReads", rdCount, 9);
        checkOutput("firstWindowStrt", strtCount, 1);
        checkOutput("firstWindowLast", lastCount, 1);
        checkOutput("firstWindowBase", firstAddr, 0);

        // Busy core holds off a fully written frame, then the whole frame runs.
        rst_n = 1'b0;
        applyStimulus(1'b0, IMG_W * IMG_H, 1'b1);
        waitCycles(2);
        rst_n = 1'b1;
        rdCount   = 0;
        strtCount = 0;
        lastCount = 0;
        lastStrtCycle = -1;
        minPeriod = 1000000;
        waitCycles(20);
        checkOutput("busyHoldsOff", rdCount, 0);
        applyStimulus(1'b0, IMG_W * IMG_H, 1'b0);
        waitRdEn("timeoutBusyRelease", 10, n);
        checkOutput("busyReleaseLatency", n, 1);
        n = 0;
        while (bus.frame_done !== 1'b1 && n < 8000) begin
            waitCycles(1);
            n++;
        end
        checkOutput("frameDoneReached", bus.frame_done, 1);
        waitCycles(5);
        checkOutput("frameStrtCount", strtCount, (IMG_H - 2) * (IMG_W - 2));
        checkOutput("frameLastCount", lastCount, (IMG_H - 2) * (IMG_W - 2));
        checkOutput("frameReadCount", rdCount, 9 * (IMG_H - 2) * (IMG_W - 2));
        checkOutput("lastWindowBase", lastBase, 725);
        checkOutput("lastWindowAddr", lastAddr, 783);
        checkOutput("wrapEndAddr", wrapEnd, 83);
        checkOutput("wrapNextAddr", wrapNext, 28);
        checkOutput("minWindowPeriod", minPeriod, 11);
        rdSnap = rdCount;
        waitCycles(20);
        checkOutput("frameDoneHeld", bus.frame_done, 1);
        checkOutput("noReadAfterDone", rdCount, rdSnap);

        // clr restarts the frame; a second clr at tap 4 aborts that window.
        applyStimulus(1'b1, IMG_W * IMG_H, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, IMG_W * IMG_H, 1'b0);
        checkOutput("clrFrameDone", bus.frame_done, 0);
        waitRdEn("timeoutAfterClr", 10, n);
        waitCycles(4);
        checkOutput("clrAtTap4Addr", bus.addr_rd, 2 * 0 + IMG_W + 1);
        applyStimulus(1'b1, IMG_W * IMG_H, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, IMG_W * IMG_H, 1'b0);
        snap = lastCount;
        firstAddr = -1;
        checkOutput("clrRdEn", bus.rd_en, 0);
        checkOutput("clrAddr", bus.addr_rd, 0);
        checkOutput("clrWinPos", {bus.win_row, bus.win_col}, 0);
        checkOutput("clrTapVld", bus.tap_vld, 0);
        checkOutput("clrFrameDone2", bus.frame_done, 0);
        waitCycles(4);
        checkOutput("noAbortedWinLast", lastCount, snap);
        waitCycles(10);
        checkOutput("clrRestartBase", firstAddr, 0);

        // Asynchronous reset in the middle of a fetch.
        waitRdEn("timeoutBeforeReset", 30, n);
        waitCycles(3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetOutputs",
                    {bus.rd_en, bus.addr_rd, bus.tap_vld, bus.tap_idx, bus.win_strt,
                     bus.win_last, bus.win_row, bus.win_col, bus.frame_done}, 0);
        waitCycles(2);
        firstAddr = -1;
        rst_n = 1'b1;
        waitCycles(15);
        checkOutput("resumeBase", firstAddr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
